// File: rtl/uart_fifo_tx.sv
// UART transmit engine: pops bytes from the packet FIFO and
// serialises each as start / data LSB-first / [parity] / stop.
module uart_fifo_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter bit          PARITY_EN    = 1'b1,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        soft_reset,
  input  logic        tx_enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_read_enb,
  output logic        tx,
  output logic        busy,
  output logic        tx_done,
  output logic [15:0] frames_sent
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] DATA_MAX = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_MAX = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state;
  state_t state_n;

  logic [CW-1:0]        baud_cnt;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic baud_last;
  logic data_last;
  logic stop_last;
  logic timed;

  logic tx_d;
  logic rd_d;
  logic busy_d;
  logic done_d;

  assign baud_last = (baud_cnt == BAUD_MAX);
  assign data_last = (bit_cnt == DATA_MAX);
  assign stop_last = (bit_cnt == STOP_MAX);
  assign timed = (state == START) || (state == DATA) ||
                 (state == PARITY) || (state == STOP);

  // State, datapath and registered outputs; soft_reset drops the frame
  always_ff @(posedge clock) begin
    if (!resetn || soft_reset) begin
      state         <= IDLE;
      baud_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      tx            <= 1'b1;
      fifo_read_enb <= 1'b0;
      busy          <= 1'b0;
      tx_done       <= 1'b0;
    end else begin
      state         <= state_n;
      tx            <= tx_d;
      fifo_read_enb <= rd_d;
      busy          <= busy_d;
      tx_done       <= done_d;

      if (state == LOAD) begin
        shreg   <= fifo_data[DATA_BITS-1:0];
        par_bit <= ^fifo_data[DATA_BITS-1:0] ^ PARITY_ODD;
      end else if (state == DATA && baud_last) begin
        shreg <= shreg >> 1;
      end

      if (timed)
        baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
      else
        baud_cnt <= '0;

      if (state == DATA && baud_last)
        bit_cnt <= data_last ? 3'd0 : bit_cnt + 3'd1;
      else if (state == STOP && baud_last)
        bit_cnt <= stop_last ? 3'd0 : bit_cnt + 3'd1;
      else if (state != DATA && state != STOP)
        bit_cnt <= 3'd0;
    end
  end

  // Frame counter survives soft_reset
  always_ff @(posedge clock) begin
    if (!resetn)
      frames_sent <= '0;
    else if (!soft_reset && done_d)
      frames_sent <= frames_sent + 16'd1;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (tx_enable && !fifo_empty)
          state_n = FETCH;
      end
      FETCH: state_n = LOAD;
      LOAD:  state_n = START;
      START: begin
        if (baud_last)
          state_n = DATA;
      end
      DATA: begin
        if (baud_last && data_last)
          state_n = PARITY_EN ? PARITY : STOP;
      end
      PARITY: begin
        if (baud_last)
          state_n = STOP;
      end
      STOP: begin
        if (baud_last && stop_last)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // tx follows the current state one clock later; the pop
  // strobe and busy are aligned with the state itself
  always_comb begin
    tx_d = 1'b1;
    unique case (state)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg[0];
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
    rd_d   = (state_n == FETCH);
    busy_d = (state_n != IDLE);
    done_d = (state == STOP) && baud_last && stop_last;
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: FIFO model, serial monitor and
// frame scoreboard on two parameterisations.
module tb_uart_fifo_tx;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  logic soft_reset = 1'b0;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  logic fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;

  logic rd_a, tx_a, busy_a, done_a;
  logic rd_b, tx_b, busy_b, done_b;
  logic [15:0] frames_a, frames_b;

  always #5 clock = ~clock;

  uart_fifo_tx #(
    .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1'b1),
    .PARITY_ODD(1'b0), .STOP_BITS(1)
  ) dut_a (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .tx_enable(en_a), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read_enb(rd_a), .tx(tx_a),
    .busy(busy_a), .tx_done(done_a), .frames_sent(frames_a)
  );

  uart_fifo_tx #(
    .CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1'b0),
    .PARITY_ODD(1'b0), .STOP_BITS(2)
  ) dut_b (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .tx_enable(en_b), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read_enb(rd_b), .tx(tx_b),
    .busy(busy_b), .tx_done(done_b), .frames_sent(frames_b)
  );

  typedef struct {
    logic [7:0]  data;
    logic [10:0] fa;
    logic [10:0] fb;
  } vec_t;

  typedef struct {
    logic [10:0] bits;
    bit          glitch;
    int          t;
  } got_t;

  vec_t        tbl[8];
  logic [7:0]  fq[$];
  logic [10:0] exp_q[$];
  got_t        got_q[$];
  int          times_q[$];

  int errors = 0;
  int checks = 0;

  // FIFO model: data valid the cycle after the pop strobe
  int underflow = 0;
  always @(posedge clock) begin
    if (rd_a || rd_b) begin
      if (fq.size() > 0) fifo_data <= fq.pop_front();
      else underflow++;
    end
  end
  always @(negedge clock) fifo_empty = (fq.size() == 0);

  // Event counters and serial monitor, sampled on negedge
  logic mon_on = 1'b1;
  logic mon_sel = 1'b0;
  logic txm;
  assign txm = mon_sel ? tx_b : tx_a;

  int cyc = 0;
  int rd_cnt = 0;
  int rdb_cnt = 0;
  int rd_dbl = 0;
  int done_cnt = 0;
  int doneb_cnt = 0;
  int txlow_cnt = 0;
  logic rd_prev = 1'b0;
  int mcnt = -1;
  logic [10:0] mbits = '0;
  bit mglitch = 1'b0;
  int mstart = 0;

  always @(negedge clock) begin
    cyc++;
    if (rd_a) rd_cnt++;
    if (rd_b) rdb_cnt++;
    if ((rd_a || rd_b) && rd_prev) rd_dbl++;
    rd_prev = rd_a || rd_b;
    if (done_a) done_cnt++;
    if (done_b) doneb_cnt++;
    if (tx_a === 1'b0) txlow_cnt++;
    if (!mon_on) begin
      mcnt = -1;
    end else begin
      if (mcnt < 0 && txm === 1'b0) begin
        mcnt = 0;
        mglitch = 1'b0;
        mstart = cyc;
      end
      if (mcnt >= 0) begin
        if (mcnt % 4 == 0) mbits[mcnt/4] = txm;
        else if (txm !== mbits[mcnt/4]) mglitch = 1'b1;
        mcnt++;
        if (mcnt == 44) begin
          got_q.push_back('{mbits, mglitch, mstart});
          mcnt = -1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [10:0] f,
                      input bit expect_it);
    fq.push_back(d);
    if (expect_it) exp_q.push_back(f);
  endtask

  task automatic take_frames(input int n);
    got_t g;
    logic [10:0] e;
    for (int k = 0; k < n; k++) begin
      int t = 0;
      while (got_q.size() == 0 && t < 400) begin
        @(negedge clock);
        t++;
      end
      if (got_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_timeout: got no frame, required frame %0d", k);
      end else begin
        g = got_q.pop_front();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 11'bx;
        chk("frame", {20'd0, g.glitch, g.bits}, {20'd0, 1'b0, e});
        times_q.push_back(g.t);
      end
    end
  endtask

  task automatic wait_tx_low();
    int t = 0;
    while (tx_a !== 1'b0 && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (tx_a !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: tx=%b, required 0", tx_a);
    end
  endtask

  initial begin
    int rd0, done0, low0;
    logic [15:0] fs0;

    // {data, frame A (even parity, 1 stop), frame B (2 stops)}
    // frame bit 0 = start bit, in time order toward the MSB
    tbl[0] = '{8'hA5, 11'b1_0_10100101_0, 11'b1_1_10100101_0};
    tbl[1] = '{8'h00, 11'b1_0_00000000_0, 11'b1_1_00000000_0};
    tbl[2] = '{8'hFF, 11'b1_0_11111111_0, 11'b1_1_11111111_0};
    tbl[3] = '{8'h3C, 11'b1_0_00111100_0, 11'b1_1_00111100_0};
    tbl[4] = '{8'h01, 11'b1_1_00000001_0, 11'b1_1_00000001_0};
    tbl[5] = '{8'h13, 11'b1_1_00010011_0, 11'b1_1_00010011_0};
    tbl[6] = '{8'h7E, 11'b1_0_01111110_0, 11'b1_1_01111110_0};
    tbl[7] = '{8'h80, 11'b1_1_10000000_0, 11'b1_1_10000000_0};

    // Reset and idle with an empty FIFO
    repeat (2) @(negedge clock);
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_rd", 32'(rd_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_frames", 32'(frames_a), 32'd0);
    resetn = 1'b1;
    en_a = 1'b1;
    rd0 = rd_cnt;
    low0 = txlow_cnt;
    repeat (20) @(negedge clock);
    chk("idle_rd", 32'(rd_cnt - rd0), 32'd0);
    chk("idle_txlow", 32'(txlow_cnt - low0), 32'd0);
    chk("idle_busy", 32'(busy_a), 32'd0);

    // Single byte 0xA5, even parity
    rd0 = rd_cnt;
    done0 = done_cnt;
    push(tbl[0].data, tbl[0].fa, 1'b1);
    take_frames(1);
    repeat (4) @(negedge clock);
    chk("a5_done", 32'(done_cnt - done0), 32'd1);
    chk("a5_frames", 32'(frames_a), 32'd1);
    chk("a5_rd", 32'(rd_cnt - rd0), 32'd1);

    // Burst of queued bytes: order, pops and 3-cycle gaps
    en_a = 1'b0;
    rd0 = rd_cnt;
    done0 = done_cnt;
    for (int i = 1; i <= 5; i++) push(tbl[i].data, tbl[i].fa, 1'b1);
    repeat (5) @(negedge clock);
    times_q.delete();
    en_a = 1'b1;
    take_frames(5);
    repeat (4) @(negedge clock);
    for (int i = 1; i < times_q.size(); i++)
      chk("gap", 32'(times_q[i] - times_q[i-1]), 32'd47);
    chk("burst_rd", 32'(rd_cnt - rd0), 32'd5);
    chk("burst_done", 32'(done_cnt - done0), 32'd5);
    chk("burst_frames", 32'(frames_a), 32'd6);

    // tx_enable low holds off a non-empty FIFO
    en_a = 1'b0;
    push(tbl[6].data, tbl[6].fa, 1'b1);
    rd0 = rd_cnt;
    low0 = txlow_cnt;
    repeat (100) @(negedge clock);
    chk("hold_rd", 32'(rd_cnt - rd0), 32'd0);
    chk("hold_txlow", 32'(txlow_cnt - low0), 32'd0);
    en_a = 1'b1;
    @(negedge clock);
    chk("lat_rd1", 32'(rd_a), 32'd1);
    @(negedge clock);
    chk("lat_rd0", 32'(rd_a), 32'd0);
    chk("lat_tx_fetch", 32'(tx_a), 32'd1);
    @(negedge clock);
    chk("lat_tx_load", 32'(tx_a), 32'd1);
    @(negedge clock);
    chk("lat_tx_start", 32'(tx_a), 32'd0);
    take_frames(1);
    repeat (4) @(negedge clock);
    chk("lat_frames", 32'(frames_a), 32'd7);

    // soft_reset during data bit 3
    mon_on = 1'b0;
    fs0 = frames_a;
    rd0 = rd_cnt;
    push(8'h5A, 11'd0, 1'b0);
    wait_tx_low();
    repeat (17) @(negedge clock);
    soft_reset = 1'b1;
    @(negedge clock);
    soft_reset = 1'b0;
    chk("soft_tx", 32'(tx_a), 32'd1);
    chk("soft_busy", 32'(busy_a), 32'd0);
    chk("soft_frames", 32'(frames_a), 32'(fs0));
    low0 = txlow_cnt;
    repeat (60) @(negedge clock);
    chk("soft_pops", 32'(rd_cnt - rd0), 32'd1);
    chk("soft_noresend", 32'(txlow_cnt - low0), 32'd0);

    // Hard reset during the stop bit: no tx_done
    done0 = done_cnt;
    push(8'hC3, 11'd0, 1'b0);
    wait_tx_low();
    repeat (41) @(negedge clock);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    repeat (10) @(negedge clock);
    chk("hard_done", 32'(done_cnt - done0), 32'd0);
    chk("hard_frames", 32'(frames_a), 32'd0);
    chk("hard_tx", 32'(tx_a), 32'd1);
    chk("hard_busy", 32'(busy_a), 32'd0);
    mon_on = 1'b1;

    // frames_sent wraps 0xFFFF -> 0
    force dut_a.frames_sent = 16'hFFFF;
    @(negedge clock);
    release dut_a.frames_sent;
    @(negedge clock);
    chk("wrap_pre", 32'(frames_a), 32'h0000FFFF);
    done0 = done_cnt;
    push(tbl[5].data, tbl[5].fa, 1'b1);
    take_frames(1);
    repeat (4) @(negedge clock);
    chk("wrap_done", 32'(done_cnt - done0), 32'd1);
    chk("wrap_frames", 32'(frames_a), 32'd0);

    // No parity, two stop bits
    en_a = 1'b0;
    repeat (4) @(negedge clock);
    mon_sel = 1'b1;
    en_b = 1'b1;
    done0 = doneb_cnt;
    push(tbl[7].data, tbl[7].fb, 1'b1);
    push(tbl[3].data, tbl[3].fb, 1'b1);
    take_frames(2);
    repeat (4) @(negedge clock);
    chk("b_done", 32'(doneb_cnt - done0), 32'd2);
    chk("b_frames", 32'(frames_b), 32'd2);
    chk("b_pops", 32'(rdb_cnt), 32'd2);
    chk("b_busy", 32'(busy_b), 32'd0);

    chk("rd_single", 32'(rd_dbl), 32'd0);
    chk("underflow", 32'(underflow), 32'd0);
    chk("left_expected", 32'(exp_q.size()), 32'd0);
    chk("left_frames", 32'(got_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
